// File: rtl/weight_buffer_pkg.sv
// Shared types and helpers for the ping-pong weight buffer.
package weight_buffer_pkg;

    localparam int DEF_INPUT_WIDTH  = 32;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_KMAX         = 5;
    localparam int LANES            = DEF_INPUT_WIDTH / DEF_WEIGHT_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } wr_state_t;

    // Zero means "one"; anything past the array size saturates to KMAX.
    function automatic logic [3:0] clamp_dim(input logic [3:0] v, input int kmax);
        if (v == 4'd0)
            return 4'd1;
        if (int'(v) > kmax)
            return 4'(kmax);
        return v;
    endfunction

    // Input words needed to carry r*s weights.
    function automatic int words_needed(input logic [3:0] r, input logic [3:0] s,
                                        input int ww, input int iw);
        return (int'(r) * int'(s) * ww + iw - 1) / iw;
    endfunction

    // Advance a row-major (row, col) position by one weight for width s.
    function automatic logic [7:0] next_pos(input logic [3:0] row, input logic [3:0] col,
                                            input logic [3:0] s);
        if (col + 4'd1 >= s)
            return {row + 4'd1, 4'd0};
        return {row, col + 4'd1};
    endfunction

endpackage

// File: rtl/weight_buffer_pp_bank.sv
// One KMAX x KMAX weight bank with clear and multi-lane row-major write.
module weight_bank
    import weight_buffer_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int KMAX         = 5,
    parameter int NLANES       = 4
) (
    input  logic                                CLK,
    input  logic                                RESETN,
    input  logic                                clr,
    input  logic                                wr_en,
    input  logic [3:0]                          row,
    input  logic [3:0]                          col,
    input  logic [3:0]                          s,
    input  logic [7:0]                          cnt,
    input  logic [NLANES*WEIGHT_WIDTH-1:0]      data,
    output logic [KMAX*KMAX*WEIGHT_WIDTH-1:0]   rows
);
    localparam int ROW_WIDTH = KMAX * WEIGHT_WIDTH;

    logic [WEIGHT_WIDTH-1:0] mem [KMAX][KMAX];
    logic [3:0]              lrow [NLANES];
    logic [3:0]              lcol [NLANES];
    logic [WEIGHT_WIDTH-1:0] lw   [NLANES];

    // Destination cell of every lane: consecutive weights, wrapping at width s.
    always_comb begin
        logic [7:0] p;
        p = {row, col};
        for (int i = 0; i < NLANES; i++) begin
            lrow[i] = p[7:4];
            lcol[i] = p[3:0];
            lw[i]   = data[NLANES*WEIGHT_WIDTH-1-i*WEIGHT_WIDTH -: WEIGHT_WIDTH];
            p       = next_pos(p[7:4], p[3:0], s);
        end
    end

    // Storage: clear on a new filter, then overlay the lanes of this word.
    always_ff @(posedge CLK) begin
        for (int r = 0; r < KMAX; r++) begin
            for (int c = 0; c < KMAX; c++) begin
                if (!RESETN) begin
                    mem[r][c] <= '0;
                end else begin
                    if (clr)
                        mem[r][c] <= '0;
                    for (int i = 0; i < NLANES; i++)
                        if (wr_en && 8'(i) < cnt && lrow[i] == 4'(r) && lcol[i] == 4'(c))
                            mem[r][c] <= lw[i];
                end
            end
        end
    end

    // Row 0 sits in the top bits, columns left-aligned within a row.
    always_comb begin
        rows = '0;
        for (int r = 0; r < KMAX; r++)
            for (int c = 0; c < KMAX; c++)
                rows[(KMAX-r)*ROW_WIDTH-1-c*WEIGHT_WIDTH -: WEIGHT_WIDTH] = mem[r][c];
    end

endmodule

// File: rtl/weight_buffer_pp.sv
// Ping-pong filter weight buffer: load shadow bank while MAC reads active bank.
module weight_buffer_pp
    import weight_buffer_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int KMAX         = DEF_KMAX
) (
    input  logic                              CLK,
    input  logic                              RESETN,
    input  logic                              WR_VALID,
    output logic                              WR_READY,
    input  logic [INPUT_WIDTH-1:0]            WR_DATA,
    input  logic [3:0]                        PARAM_R,
    input  logic [3:0]                        PARAM_S,
    output logic                              RD_VALID,
    input  logic                              RD_RELEASE,
    output logic [KMAX*KMAX*WEIGHT_WIDTH-1:0] RD_DATA,
    output logic [3:0]                        RD_R,
    output logic [3:0]                        RD_S
);
    localparam int WLANES = INPUT_WIDTH / WEIGHT_WIDTH;
    localparam int BANKW  = KMAX * KMAX * WEIGHT_WIDTH;

    wr_state_t             state;
    logic                  act, rd_valid, wr_ready;
    logic [1:0][3:0]       r_bank, s_bank;
    logic [7:0]            word_cnt, n_words, k, tot;
    logic [3:0]            wr_row, wr_col;
    logic [1:0][BANKW-1:0] bank_rows;

    logic       xfer, first, wb, last, swap_now;
    logic [3:0] eff_r, eff_s, st_row, st_col, nx_row, nx_col;
    logic [7:0] eff_tot, eff_k, n_first, rem, cnt;

    // Per-word control: which dimensions/position apply and how many lanes land.
    always_comb begin
        logic [7:0] p;
        xfer    = WR_VALID && wr_ready;
        first   = (state == IDLE);
        wb      = ~act;
        eff_r   = first ? clamp_dim(PARAM_R, KMAX) : r_bank[wb];
        eff_s   = first ? clamp_dim(PARAM_S, KMAX) : s_bank[wb];
        eff_tot = first ? ({4'd0, eff_r} * {4'd0, eff_s}) : tot;
        n_first = 8'(words_needed(eff_r, eff_s, WEIGHT_WIDTH, INPUT_WIDTH));
        eff_k   = first ? 8'd0 : k;
        st_row  = first ? 4'd0 : wr_row;
        st_col  = first ? 4'd0 : wr_col;
        rem     = eff_tot - eff_k;
        cnt     = (rem > 8'(WLANES)) ? 8'(WLANES) : rem;
        p       = {st_row, st_col};
        for (int i = 0; i < WLANES; i++)
            p = next_pos(p[7:4], p[3:0], eff_s);
        nx_row   = p[7:4];
        nx_col   = p[3:0];
        last     = xfer && (first ? (n_first == 8'd1) : (word_cnt == n_words - 8'd1));
        swap_now = (last && (!rd_valid || RD_RELEASE)) || (state == WAIT_SWAP && RD_RELEASE);
    end

    // Write FSM, load counters and the ping-pong pointer.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= IDLE;
            act      <= 1'b0;
            rd_valid <= 1'b0;
            wr_ready <= 1'b1;
            r_bank   <= '0;
            s_bank   <= '0;
            word_cnt <= '0;
            n_words  <= '0;
            k        <= '0;
            tot      <= '0;
            wr_row   <= '0;
            wr_col   <= '0;
        end else begin
            if (xfer) begin
                word_cnt <= first ? 8'd1 : word_cnt + 8'd1;
                k        <= eff_k + 8'(WLANES);
                wr_row   <= nx_row;
                wr_col   <= nx_col;
            end
            if (xfer && first) begin
                r_bank[wb] <= eff_r;
                s_bank[wb] <= eff_s;
                n_words    <= n_first;
                tot        <= eff_tot;
            end
            if (last) begin
                state    <= swap_now ? IDLE : WAIT_SWAP;
                wr_ready <= swap_now;
            end else if (xfer && first) begin
                state <= LOAD;
            end else if (state == WAIT_SWAP && RD_RELEASE) begin
                state    <= IDLE;
                wr_ready <= 1'b1;
            end
            if (swap_now) begin
                act      <= ~act;
                rd_valid <= 1'b1;
            end else if (RD_RELEASE) begin
                rd_valid <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        weight_bank #(
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .KMAX        (KMAX),
            .NLANES      (WLANES)
        ) u_bank (
            .CLK   (CLK),
            .RESETN(RESETN),
            .clr   (xfer && first && (wb == 1'(b))),
            .wr_en (xfer && (wb == 1'(b))),
            .row   (st_row),
            .col   (st_col),
            .s     (eff_s),
            .cnt   (cnt),
            .data  (WR_DATA),
            .rows  (bank_rows[b])
        );
    end

    assign WR_READY = wr_ready;
    assign RD_VALID = rd_valid;
    assign RD_DATA  = bank_rows[act];
    assign RD_R     = r_bank[act];
    assign RD_S     = s_bank[act];

endmodule

// File: tb/tb_weight_buffer_pp.sv
// Scoreboard bench for the ping-pong weight buffer.
module tb_weight_buffer_pp;
    localparam int IW   = 32;
    localparam int WW   = 8;
    localparam int KMAX = 5;
    localparam int RW   = KMAX * WW;
    localparam int TOTW = KMAX * RW;

    logic            CLK = 1'b0;
    logic            RESETN = 1'b0;
    logic            WR_VALID = 1'b0;
    logic            WR_READY;
    logic [IW-1:0]   WR_DATA = '0;
    logic [3:0]      PARAM_R = '0;
    logic [3:0]      PARAM_S = '0;
    logic            RD_VALID;
    logic            RD_RELEASE = 1'b0;
    logic [TOTW-1:0] RD_DATA;
    logic [3:0]      RD_R;
    logic [3:0]      RD_S;

    weight_buffer_pp #(.INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .KMAX(KMAX)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .WR_VALID  (WR_VALID),
        .WR_READY  (WR_READY),
        .WR_DATA   (WR_DATA),
        .PARAM_R   (PARAM_R),
        .PARAM_S   (PARAM_S),
        .RD_VALID  (RD_VALID),
        .RD_RELEASE(RD_RELEASE),
        .RD_DATA   (RD_DATA),
        .RD_R      (RD_R),
        .RD_S      (RD_S)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]      r;
        logic [3:0]      s;
        logic [TOTW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    always @(posedge CLK)
        if (RESETN && WR_VALID && WR_READY)
            xfers <= xfers + 1;

    task automatic check(input string tag, input logic [TOTW-1:0] got, input logic [TOTW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clampd(input int v);
        if (v == 0) return 1;
        if (v > KMAX) return KMAX;
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input int k, input int tot, input int base);
        if (k < tot) return 8'(base + k);
        return 8'(8'hAA + 8'h11 * (k - tot));
    endfunction

    // Reference placement: weight k -> row k/s, column k%s.
    function automatic logic [TOTW-1:0] model(input int r, input int s, input int base);
        logic [TOTW-1:0] m;
        m = '0;
        for (int kk = 0; kk < r * s; kk++)
            m[(KMAX - kk / s) * RW - 1 - (kk % s) * WW -: WW] = 8'(base + kk);
        return m;
    endfunction

    task automatic drive_load(input int pr, input int ps, input int base,
                              input bit rel_last, input bit watch);
        int   r, s, tot, n, t;
        exp_t e;
        logic [IW-1:0] w;
        r = clampd(pr);
        s = clampd(ps);
        tot = r * s;
        n = (tot * WW + IW - 1) / IW;
        e.r = 4'(r);
        e.s = 4'(s);
        e.data = model(r, s, base);
        sb.push_back(e);
        for (int j = 0; j < n; j++) begin
            @(negedge CLK);
            if (watch) check("valid_hold", TOTW'(RD_VALID), TOTW'(1'b1));
            for (int i = 0; i < IW / WW; i++)
                w[IW-1-i*WW -: WW] = byte_at(j * (IW / WW) + i, tot, base);
            WR_VALID   = 1'b1;
            WR_DATA    = w;
            PARAM_R    = (j == 0) ? 4'(pr) : 4'(pr + 3);
            PARAM_S    = (j == 0) ? 4'(ps) : 4'(ps + 2);
            RD_RELEASE = rel_last && (j == n - 1);
            t = 0;
            while (!WR_READY && t < 20) begin
                @(negedge CLK);
                t++;
            end
            if (!WR_READY) check("ready_timeout", TOTW'(WR_READY), TOTW'(1'b1));
            @(posedge CLK);
        end
        @(negedge CLK);
        WR_VALID   = 1'b0;
        RD_RELEASE = 1'b0;
        if (watch) check("valid_hold", TOTW'(RD_VALID), TOTW'(1'b1));
    endtask

    task automatic check_visible(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, TOTW'(0), TOTW'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, TOTW'(RD_VALID), TOTW'(1'b1));
            check({tag, "_r"}, TOTW'(RD_R), TOTW'(e.r));
            check({tag, "_s"}, TOTW'(RD_S), TOTW'(e.s));
            check({tag, "_data"}, RD_DATA, e.data);
            cur = e;
        end
    endtask

    task automatic pulse_release();
        @(negedge CLK);
        RD_RELEASE = 1'b1;
        @(negedge CLK);
        RD_RELEASE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_valid", TOTW'(RD_VALID), TOTW'(1'b0));
        check("rst_ready", TOTW'(WR_READY), TOTW'(1'b1));
        check("rst_r", TOTW'(RD_R), TOTW'(4'd0));
        check("rst_s", TOTW'(RD_S), TOTW'(4'd0));
        check("rst_data", RD_DATA, '0);
        RESETN = 1'b1;

        // 3x3 into a free buffer: visible the cycle after the last word
        drive_load(3, 3, 1, 1'b0, 1'b0);
        check_visible("3x3");
        check("3x3_row0", TOTW'(RD_DATA[TOTW-1 -: RW]), TOTW'(40'h0102030000));
        check("3x3_row2", TOTW'(RD_DATA[TOTW-1-2*RW -: RW]), TOTW'(40'h0708090000));

        // 1x1 load while 3x3 still held: stalls in WAIT_SWAP
        drive_load(1, 1, 8'h7F, 1'b0, 1'b0);
        check("pp_ready_lo", TOTW'(WR_READY), TOTW'(1'b0));
        repeat (3) @(negedge CLK);
        check("pp_ready_hold", TOTW'(WR_READY), TOTW'(1'b0));
        check("pp_keep_a", RD_DATA, cur.data);
        check("pp_keep_r", TOTW'(RD_R), TOTW'(cur.r));
        pulse_release();
        check_visible("pp_b");
        check("pp_b_row0", TOTW'(RD_DATA[TOTW-1 -: RW]), TOTW'(40'h7F00000000));
        check("pp_ready_hi", TOTW'(WR_READY), TOTW'(1'b1));

        // 5x5 with release on the last word: direct swap, valid never drops
        drive_load(5, 5, 1, 1'b1, 1'b1);
        check_visible("5x5");
        check("5x5_row0", TOTW'(RD_DATA[TOTW-1 -: RW]), TOTW'(40'h0102030405));
        check("5x5_row4", TOTW'(RD_DATA[RW-1:0]), TOTW'(40'h1516171819));
        check("5x5_ready", TOTW'(WR_READY), TOTW'(1'b1));

        // bare release empties the buffer; a second one is ignored
        pulse_release();
        check("rel_valid", TOTW'(RD_VALID), TOTW'(1'b0));
        pulse_release();
        check("rel_ignored", TOTW'(RD_VALID), TOTW'(1'b0));
        check("rel_ready", TOTW'(WR_READY), TOTW'(1'b1));

        // clamped dimensions: R=0 -> 1, S=9 -> 5, two words
        x0 = xfers;
        drive_load(0, 9, 8'h30, 1'b0, 1'b0);
        check("clamp_words", TOTW'(xfers - x0), TOTW'(2));
        check_visible("clamp");

        // reset in the middle of a 5x5 load discards everything
        for (int j = 0; j < 2; j++) begin
            @(negedge CLK);
            WR_VALID = 1'b1;
            WR_DATA  = 32'hDEADBEEF;
            PARAM_R  = 4'd5;
            PARAM_S  = 4'd5;
            @(posedge CLK);
        end
        @(negedge CLK);
        WR_VALID = 1'b0;
        RESETN   = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        check("mid_rst_valid", TOTW'(RD_VALID), TOTW'(1'b0));
        check("mid_rst_data", RD_DATA, '0);
        check("mid_rst_ready", TOTW'(WR_READY), TOTW'(1'b1));

        // fresh loads after reset, including an exact word multiple
        drive_load(2, 2, 8'h40, 1'b0, 1'b0);
        check_visible("fresh_2x2");
        drive_load(4, 4, 8'h60, 1'b0, 1'b0);
        check("4x4_wait", TOTW'(WR_READY), TOTW'(1'b0));
        pulse_release();
        check_visible("4x4");
        drive_load(2, 5, 8'h80, 1'b1, 1'b1);
        check_visible("2x5");

        check("sb_drained", TOTW'(sb.size()), TOTW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_buffer_pp.md
Name: weight_buffer_pp

Overview:
Parametrised, double-buffered (ping-pong) filter weight buffer for the conv engine. It unpacks a dense, row-major stream of WEIGHT_WIDTH-bit weights from INPUT_WIDTH-bit words into KMAX row registers for any R x S filter up to KMAX x KMAX. A second filter loads into the shadow bank while the MAC array consumes the active bank. A consumer release/swap handshake replaces the single-bank FULL flag.

Parameters:
INPUT_WIDTH, 32, width of input word; must be a multiple of WEIGHT_WIDTH
WEIGHT_WIDTH, 8, bits per weight
KMAX, 5, max filter height/width; ROW_WIDTH = KMAX*WEIGHT_WIDTH

Ports:
CLK  in  1  clock
RESETN  in  1  synchronous active-low reset
WR_VALID  in  1  input word valid
WR_READY  out  1  buffer accepts word (transfer = WR_VALID & WR_READY)
WR_DATA  in  INPUT_WIDTH  packed weights, first weight in MSBs
PARAM_R  in  4  filter height, sampled on first word of a load
PARAM_S  in  4  filter width, sampled on first word of a load
RD_VALID  out  1  active bank holds a complete filter
RD_RELEASE  in  1  consumer done with active bank (1-cycle pulse)
RD_DATA  out  KMAX*ROW_WIDTH  row r at bits [(KMAX-r)*ROW_WIDTH-1 -: ROW_WIDTH]
RD_R  out  4  R of active filter
RD_S  out  4  S of active filter

Behaviour:
- Reset (RESETN=0 at posedge): both banks zero, RD_VALID=0, RD_R=RD_S=0, WR_READY=1, write FSM IDLE, all counters 0. Reset mid-load discards partial data.
- Clamp on sample: value 0 -> 1; value >KMAX -> KMAX. Store clamped R,S with the write bank.
- Word count N = ceil(R*S*WEIGHT_WIDTH/INPUT_WIDTH). Trailing weights in last word beyond R*S are ignored.
- Placement: weight k (k=0..R*S-1) goes to row k/S, column k%S. Column c occupies bits [ROW_WIDTH-1-c*WEIGHT_WIDTH -: WEIGHT_WIDTH] (left-aligned). Unused columns/rows read 0. Words may span row boundaries. Up to INPUT_WIDTH/WEIGHT_WIDTH weights are written per transfer via a row/col lane counter.
- Write FSM:
  IDLE: on transfer, sample R,S, clear write bank while writing lane 0.. of this word. If N==1, go to DONE logic; else LOAD.
  LOAD: each transfer writes the next lanes. Last word (word count == N-1) -> DONE logic.
  DONE logic, same cycle as last transfer: if RD_VALID==0 or RD_RELEASE==1, swap banks at that edge, return to IDLE. Else go to WAIT_SWAP.
  WAIT_SWAP: WR_READY=0; on RD_RELEASE, swap at that edge, go to IDLE.
- Swap: active pointer toggles; RD_VALID=1, RD_DATA/RD_R/RD_S show the new filter the cycle after the last word (latency 1). Load-to-visible is 1 cycle when the active bank is free.
- RD_RELEASE without a completing load: RD_VALID->0 next cycle. RD_RELEASE with RD_VALID=0: ignored.
- WR_READY=1 in IDLE and LOAD; 0 only in WAIT_SWAP.
- Active bank contents are stable while RD_VALID=1. The write bank is never visible on RD_DATA.
- PARAM_R/S changes mid-load are ignored.

Decomposition:
- weight_buffer_pkg: write-state enum (IDLE, LOAD, WAIT_SWAP); clamp_dim function; words_needed function; LANES = INPUT_WIDTH/WEIGHT_WIDTH constant.
- Sub-module weight_bank: one KMAX x ROW_WIDTH storage array with clear and multi-lane indexed write (row/col start, lane count). Instantiated twice; top holds the FSM, counters and ping-pong pointer.

Test Plan:
- 3x3 load, RD_VALID=0: words 0x01020304, 0x05060708, 0x09AABBCC -> cycle after third word RD_VALID=1, RD_R=RD_S=3; rows = 0x0102030000, 0x0405060000, 0x0708090000, 0, 0.
- 5x5 load of bytes 0x01..0x19 over 7 words -> row0=0x0102030405, row4=0x1516171819. Bytes of word 7 after 0x19 are ignored.
- Ping-pong: 3x3 filter A active, no release; load 1x1 filter B (0x7F000000) -> WR_READY=0 after B's word, RD_DATA still A. Pulse RD_RELEASE -> next cycle RD_R=RD_S=1, row0=0x7F00000000, WR_READY=1.
- Release coinciding with last word of a pending load -> swap with no WAIT_SWAP cycle, RD_VALID stays 1 throughout.
- PARAM_R=0, PARAM_S=9 -> clamped 1x5, 2 words accepted; RD_R=1, RD_S=5. Reset asserted after 2 of 7 words of a 5x5 load -> RD_VALID=0, all rows 0, next load starts fresh.
